vec_rotate: RTL and testbench



---
 rtl/vec_rotate.sv | 90 +++++++++
 tb/tb_vec_rotate.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vec_rotate.sv
// vec_rotate: three-stage pipelined Q1.15 2-D rotation fed by a registered
// coefficient ROM, with ready/valid handshakes and a global stall.
module vec_rotate #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_y,
  input  logic        [AW-1:0] in_angle,
  output logic        [AW-1:0] rom_addr,
  input  logic signed [DW-1:0] c1,
  input  logic signed [DW-1:0] c2,
  input  logic signed [DW-1:0] c3,
  input  logic signed [DW-1:0] c4,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_x,
  output logic signed [DW-1:0] out_y
);
  localparam logic signed [2*DW:0] HALF = {{(DW+2){1'b0}}, 1'b1, {(DW-2){1'b0}}};
  localparam logic signed [2*DW:0] MAXV = {{(DW+2){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [2*DW:0] MINV = {{(DW+2){1'b1}}, {(DW-1){1'b0}}};
  logic                   advance, accept;
  logic                   v1_q, v2_q, out_valid_q;
  logic signed [DW-1:0]   x_q, y_q, out_x_q, out_y_q;
  logic        [AW-1:0]   angle_q;
  logic signed [2*DW-1:0] p1_q, p2_q, p3_q, p4_q;
  logic signed [2*DW-1:0] p1_d, p2_d, p3_d, p4_d;
  logic signed [2*DW:0]   sx_d, sy_d;
  logic        [DW-1:0]   ox_d, oy_d;
  function automatic logic [DW-1:0] rnd_sat(input logic signed [2*DW:0] s);
    logic signed [2*DW:0] r;
    r = (s + HALF) >>> (DW-1);
    return r > MAXV ? MAXV[DW-1:0] : r < MINV ? MINV[DW-1:0] : r[DW-1:0];
  endfunction
  assign advance   = !out_valid_q || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  // While stalled the ROM keeps being addressed with the S1 angle so its
  // registered output stays matched to the sample waiting in S1.
  assign rom_addr  = accept ? in_angle : angle_q;
  assign p1_d      = (2*DW)'(c1) * (2*DW)'(x_q);
  assign p2_d      = (2*DW)'(c2) * (2*DW)'(y_q);
  assign p3_d      = (2*DW)'(c3) * (2*DW)'(x_q);
  assign p4_d      = (2*DW)'(c4) * (2*DW)'(y_q);
  assign sx_d      = {p1_q[2*DW-1], p1_q} + {p2_q[2*DW-1], p2_q};
  assign sy_d      = {p3_q[2*DW-1], p3_q} + {p4_q[2*DW-1], p4_q};
  assign ox_d      = rnd_sat(sx_d);
  assign oy_d      = rnd_sat(sy_d);
  assign out_valid = out_valid_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      angle_q     <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      p3_q        <= '0;
      p4_q        <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
    end else if (advance) begin
      v1_q <= accept;
      if (accept) begin
        x_q     <= in_x;
        y_q     <= in_y;
        angle_q <= in_angle;
      end
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      p3_q        <= p3_d;
      p4_q        <= p4_d;
      v2_q        <= v1_q;
      out_valid_q <= v2_q;
      if (v2_q) begin
        out_x_q <= ox_d;
        out_y_q <= oy_d;
      end
    end
  end
endmodule

// File: tb/tb_vec_rotate.sv
// tb_vec_rotate: randomized and directed checks of vec_rotate against a
// floating-free integer Q15 rotation model with its own coefficient ROM.
module tb_vec_rotate;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 1;
  logic [15:0] in_x = 0, in_y = 0, out_x, out_y;
  logic [3:0]  in_angle = 0, rom_addr;
  logic [15:0] c1, c2, c3, c4;
  logic [15:0] rom [16][4];
  typedef struct packed {logic [15:0] x, y;} res_t;
  res_t        q[$];
  res_t        e;
  int          total = 0, bad = 0, run = 0, max_run = 0;
  bit          acc = 0, hold = 0;
  logic [15:0] hx, hy;

  always #5 clk = ~clk;

  vec_rotate dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_angle(in_angle), .rom_addr(rom_addr),
    .c1(c1), .c2(c2), .c3(c3), .c4(c4), .out_valid(out_valid),
    .out_ready(out_ready), .out_x(out_x), .out_y(out_y)
  );

  always @(posedge clk) begin
    c1 <= rom[rom_addr][0];
    c2 <= rom[rom_addr][1];
    c3 <= rom[rom_addr][2];
    c4 <= rom[rom_addr][3];
  end

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One rotated component: round-half-up of (ca*a + cb*b) / 2^15, then clamp.
  function automatic logic [15:0] rot(logic [15:0] ca, logic [15:0] cb, logic [15:0] a, logic [15:0] b);
    longint s, r;
    s = longint'($signed(ca)) * longint'($signed(a)) + longint'($signed(cb)) * longint'($signed(b));
    r = (s + 16384) >>> 15;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      acc = in_valid && in_ready;
      check("in_ready", in_ready, !out_valid || out_ready);
      if (acc) begin
        check("rom_addr", rom_addr, in_angle);
        q.push_back('{rot(rom[in_angle][0], rom[in_angle][1], in_x, in_y),
                      rot(rom[in_angle][2], rom[in_angle][3], in_x, in_y)});
      end
      if (hold) begin
        check("stall_valid", out_valid, 1);
        check("stall_x", out_x, hx);
        check("stall_y", out_y, hy);
      end
      hold = out_valid && !out_ready;
      hx = out_x;
      hy = out_y;
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (out_valid && out_ready) begin
        if (q.size() == 0) check("spurious", 1, 0);
        else begin
          e = q.pop_front();
          check("out_x", out_x, e.x);
          check("out_y", out_y, e.y);
        end
      end
    end else begin
      acc = 0;
      hold = 0;
    end
  end

  task automatic directed(string tag, logic [3:0] a, logic [15:0] x, logic [15:0] y, logic [15:0] ex, logic [15:0] ey);
    @(posedge clk); #1;
    in_valid = 1; in_angle = a; in_x = x; in_y = y; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    @(negedge clk); check({tag, "_n"}, out_valid, 0);
    @(posedge clk); @(negedge clk); check({tag, "_n1"}, out_valid, 0);
    @(posedge clk); @(negedge clk); check({tag, "_n2"}, out_valid, 1);
    check({tag, "_x"}, out_x, ex);
    check({tag, "_y"}, out_y, ey);
  endtask

  task automatic stream(int n, bit bp);
    int sent = 0, cyc = 0;
    while (sent < n && cyc < 5000) begin
      @(posedge clk); #1;
      if (acc) sent++;
      cyc++;
      if (sent < n) begin
        in_valid = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
        in_x     = 16'($urandom);
        in_y     = 16'($urandom);
        in_angle = bp ? 4'($urandom) : sent[3:0];
      end else in_valid = 0;
      out_ready = bp ? ((cyc >= 10 && cyc < 15) ? 1'b0 : 1'($urandom_range(0, 1))) : 1'b1;
    end
    if (sent < n) check("stream_timeout", sent, n);
    in_valid = 0;
  endtask

  task automatic drain(bit rnd);
    int cyc = 0;
    in_valid = 0;
    while (q.size() > 0 && cyc < 500) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cyc++;
    end
    check("drain_empty", q.size(), 0);
    @(posedge clk); #1;
    out_ready = 1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 4; j++) rom[i][j] = 16'($urandom);
    rom[1] = '{16'h0000, 16'h8001, 16'h7FFF, 16'h0000};
    rom[2] = '{16'h8000, 16'h0000, 16'h0000, 16'h8000};
    rom[3] = '{16'h5A82, 16'hA57E, 16'h5A82, 16'h5A82};
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    directed("rot90", 4'd1, 16'h4000, 16'h0000, 16'h0000, 16'h4000);
    directed("sat_prod", 4'd2, 16'h8000, 16'h0000, 16'h7FFF, 16'h0000);
    directed("sat_sum", 4'd3, 16'h7FFF, 16'h7FFF, 16'h0000, 16'h7FFF);
    drain(0);
    stream(8, 1);
    drain(1);
    max_run = 0;
    stream(16, 0);
    drain(0);
    check("burst_run", max_run, 16);
    stream(200, 1);
    drain(1);
    out_ready = 0;
    in_valid = 1;
    repeat (5) begin
      @(posedge clk); #1;
      in_x = 16'($urandom); in_y = 16'($urandom); in_angle = 4'($urandom);
    end
    check("inflight", q.size(), 3);
    #2 rst_n = 0;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_x", out_x, 0);
    check("arst_y", out_y, 0);
    q.delete();
    in_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    repeat (10) @(posedge clk);
    #1 check("post_rst_ready", in_ready, 1);
    check("post_rst_valid", out_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
